note_roll_engine: RTL and testbench

Parametrised note recorder and falling-block renderer, successor to the single-key main-state handler. In record mode it timestamps every key independently, so overlapping and simultaneous presses all become notes. In playback mode it streams one frame of note-block pixels per `frame_start` over a valid/ready pixel port. It sits between the keyboard state storage and the VGA frame writer, next to the start-screen handler.

---
 rtl/note_roll_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_note_roll_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_roll_engine.sv
// note_roll_engine
//   Records key presses as timestamped notes and, in playback, renders the
//   stored notes as falling blocks, one frame of pixels per frame_start.
//
//   State | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for frame_start in playback mode
//   FETCH | read address for note noteIdx presented to memory
//   CALC  | memory data valid; compute clipped rows, decide draw/skip
//   DRAW  | stream block pixels row-major over the valid/ready port
//   NEXT  | advance to the next note or finish the frame
//   DONE  | one-cycle frame_done pulse
//
// Ports
//   clk, resetn          : clock, async active-low reset
//   tick_us              : 1 us strobe advancing the time base
//   mode_record          : 1 = record, 0 = playback
//   restart              : record: clear memory; playback: rewind time
//   key_state            : held keys, bit k = lane k
//   frame_start          : request one frame (playback only)
//   pix_x/pix_y/pix_colour, pix_valid, pix_ready : pixel stream
//   frame_done           : pulse after the last pixel of a frame
//   mem_full             : sticky, a note was dropped
//   note_count           : number of stored notes
module note_roll_engine #(
  parameter int          NUM_KEYS = 24,
  parameter int          DEPTH    = 128,
  parameter int          TIME_W   = 29,
  parameter int          SHIFT    = 20,
  parameter int          ROLL_H   = 92,
  parameter int          LANE_W   = 6,
  parameter logic [23:0] COLOUR   = 24'h0000FF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      tick_us,
  input  logic                      mode_record,
  input  logic                      restart,
  input  logic [NUM_KEYS-1:0]       key_state,
  input  logic                      frame_start,
  output logic [7:0]                pix_x,
  output logic [7:0]                pix_y,
  output logic [23:0]               pix_colour,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      frame_done,
  output logic                      mem_full,
  output logic [$clog2(DEPTH):0]    note_count
);

  localparam int KW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int EW      = KW + 2 * TIME_W;
  localparam int ROW_MAX = ROLL_H - 1;

  // ---------------------------------------------------------------- time base
  logic [TIME_W-1:0] now;
  logic              modeQ;
  logic              modeChange;

  assign modeChange = mode_record ^ modeQ;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      now   <= '0;
      modeQ <= 1'b0;
    end else begin
      modeQ <= mode_record;
      if (restart || modeChange)
        now <= '0;
      else if (tick_us && !(&now))
        now <= now + TIME_W'(1);
    end
  end

  // ---------------------------------------------------------------- recording
  logic [NUM_KEYS-1:0] keyQ, armed, pend, rise, fall, pendClr;
  logic [TIME_W-1:0]   startT [NUM_KEYS];
  logic [KW-1:0]       pendSel;
  logic                pendHit, recActive, noteFull, wrEn;

  assign rise      = key_state & ~keyQ;
  assign fall      = ~key_state & keyQ;
  assign recActive = mode_record && !modeChange;
  assign pendHit   = |pend;
  assign noteFull  = (note_count == CW'(DEPTH));
  assign wrEn      = recActive && !restart && pendHit && !noteFull;

  always_comb begin
    pendSel = '0;
    pendClr = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (pend[i]) pendSel = KW'(i);
    if (pendHit) pendClr[pendSel] = 1'b1;
  end

  // Only keys pressed while recording are armed, so a key already held when
  // record mode is entered never produces a note on release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keyQ       <= '0;
      armed      <= '0;
      pend       <= '0;
      note_count <= '0;
      mem_full   <= 1'b0;
    end else begin
      keyQ <= key_state;
      if (!recActive) begin
        armed <= '0;
        pend  <= '0;
      end else begin
        armed <= (armed | rise) & ~fall;
        if (restart) begin
          pend       <= '0;
          note_count <= '0;
          mem_full   <= 1'b0;
        end else begin
          pend <= (pend & ~pendClr) | (fall & armed);
          if (pendHit) begin
            if (noteFull) mem_full   <= 1'b1;
            else          note_count <= note_count + CW'(1);
          end
        end
      end
    end
  end

  // now is cleared on restart, so a press in that cycle starts at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_KEYS; i++) startT[i] <= '0;
    end else if (recActive) begin
      for (int i = 0; i < NUM_KEYS; i++)
        if (rise[i]) startT[i] <= restart ? '0 : now;
    end
  end

  // ---------------------------------------------------------------- memory
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rdData;
  logic [CW-1:0] noteIdx;

  always_ff @(posedge clk) begin
    if (wrEn) mem[note_count[AW-1:0]] <= {pendSel, startT[pendSel], now};
    rdData <= mem[noteIdx[AW-1:0]];
  end

  // ---------------------------------------------------------------- playback
  typedef enum logic [2:0] {IDLE, FETCH, CALC, DRAW, NEXT, DONE} stateT;

  stateT        state, stateNx;
  logic [CW-1:0] noteIdxNx;
  logic [7:0]   laneX0, laneX0Nx, yBot, yBotNx, curX, curXNx, curY, curYNx;
  logic [7:0]   colLeft, colLeftNx;

  logic [KW-1:0]       keyF;
  logic [TIME_W-1:0]   startF, endF;
  logic signed [TIME_W:0] ds, de;
  logic signed [31:0]  dsRow, deRow, yBotRaw, yTopRaw;
  logic [7:0]          yTopC, yBotC, laneCalc;
  logic                skip;

  assign keyF   = rdData[EW-1 -: KW];
  assign startF = rdData[2*TIME_W-1 -: TIME_W];
  assign endF   = rdData[TIME_W-1:0];

  always_comb begin
    ds       = $signed({1'b0, startF}) - $signed({1'b0, now});
    de       = $signed({1'b0, endF})   - $signed({1'b0, now});
    dsRow    = $signed({{(31 - TIME_W){ds[TIME_W]}}, ds}) >>> SHIFT;
    deRow    = $signed({{(31 - TIME_W){de[TIME_W]}}, de}) >>> SHIFT;
    yBotRaw  = ROW_MAX - dsRow;
    yTopRaw  = ROW_MAX - deRow;
    // A top below the bottom only arises from a corrupted note; skip it
    // rather than sweep the whole row range.
    skip     = (yTopRaw > ROW_MAX) || (yBotRaw < 0) || (yTopRaw > yBotRaw);
    yTopC    = (yTopRaw < 0) ? 8'd0 : yTopRaw[7:0];
    yBotC    = (yBotRaw > ROW_MAX) ? 8'(ROW_MAX) : yBotRaw[7:0];
    laneCalc = 8'(32'(keyF) * LANE_W);
  end

  always_comb begin
    stateNx   = state;
    noteIdxNx = noteIdx;
    laneX0Nx  = laneX0;
    yBotNx    = yBot;
    curXNx    = curX;
    curYNx    = curY;
    colLeftNx = colLeft;
    case (state)
      IDLE: begin
        noteIdxNx = '0;
        if (frame_start && !mode_record)
          stateNx = (note_count == '0) ? DONE : FETCH;
      end
      FETCH: stateNx = CALC;
      CALC: begin
        if (skip) begin
          stateNx = NEXT;
        end else begin
          stateNx   = DRAW;
          laneX0Nx  = laneCalc;
          curXNx    = laneCalc;
          curYNx    = yTopC;
          yBotNx    = yBotC;
          colLeftNx = 8'(LANE_W - 1);
        end
      end
      DRAW: begin
        if (pix_ready) begin
          if (colLeft == 8'd0) begin
            if (curY == yBot) begin
              stateNx = NEXT;
            end else begin
              curYNx    = curY + 8'd1;
              curXNx    = laneX0;
              colLeftNx = 8'(LANE_W - 1);
            end
          end else begin
            curXNx    = curX + 8'd1;
            colLeftNx = colLeft - 8'd1;
          end
        end
      end
      NEXT: begin
        noteIdxNx = noteIdx + CW'(1);
        stateNx   = (noteIdx + CW'(1) == note_count) ? DONE : FETCH;
      end
      DONE:    stateNx = IDLE;
      default: stateNx = IDLE;
    endcase
    // Leaving playback abandons the frame with no frame_done
    if (mode_record) stateNx = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      noteIdx <= '0;
      laneX0  <= '0;
      yBot    <= '0;
      curX    <= '0;
      curY    <= '0;
      colLeft <= '0;
    end else begin
      state   <= stateNx;
      noteIdx <= noteIdxNx;
      laneX0  <= laneX0Nx;
      yBot    <= yBotNx;
      curX    <= curXNx;
      curY    <= curYNx;
      colLeft <= colLeftNx;
    end
  end

  assign pix_valid  = (state == DRAW) && !mode_record;
  assign pix_x      = curX;
  assign pix_y      = curY;
  assign pix_colour = (state == DRAW) ? COLOUR : 24'h0;
  assign frame_done = (state == DONE) && !mode_record;

endmodule

// File: tb/tb_note_roll_engine.sv
module tb_note_roll_engine;

  localparam int          NK  = 24;
  localparam int          DP  = 4;
  localparam int          TW  = 29;
  localparam int          SH  = 4;
  localparam int          RH  = 92;
  localparam int          LW  = 6;
  localparam logic [23:0] COL = 24'h0000FF;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tick_us = 1'b0;
  logic          mode_record = 1'b0;
  logic          restart = 1'b0;
  logic [NK-1:0] key_state = '0;
  logic          frame_start = 1'b0;
  logic          pix_ready = 1'b0;
  logic [7:0]    pix_x, pix_y;
  logic [23:0]   pix_colour;
  logic          pix_valid, frame_done, mem_full;
  logic [2:0]    note_count;

  int checks = 0;
  int errors = 0;
  int tbNow  = 0;
  logic [39:0] expQ[$];

  note_roll_engine #(
    .NUM_KEYS(NK), .DEPTH(DP), .TIME_W(TW), .SHIFT(SH),
    .ROLL_H(RH), .LANE_W(LW), .COLOUR(COL)
  ) dut (
    .clk(clk), .resetn(resetn), .tick_us(tick_us), .mode_record(mode_record),
    .restart(restart), .key_state(key_state), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done),
    .mem_full(mem_full), .note_count(note_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int n);
    tick_us = 1'b1;
    step(n);
    tick_us = 1'b0;
    tbNow += n;
  endtask

  task automatic setMode(input bit m);
    mode_record = m;
    step(1);
    tbNow = 0;
  endtask

  task automatic pulseRestart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    tbNow = 0;
  endtask

  task automatic startFrame();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  // Expected pixels of one note at the current playback time
  task automatic pushNote(input int k, input int s, input int e);
    int ds, de, yb, yt;
    ds = (s - tbNow) >>> SH;
    de = (e - tbNow) >>> SH;
    yb = RH - 1 - ds;
    yt = RH - 1 - de;
    if (yt > RH - 1 || yb < 0) return;
    if (yt < 0) yt = 0;
    if (yb > RH - 1) yb = RH - 1;
    for (int y = yt; y <= yb; y++)
      for (int x = k * LW; x < k * LW + LW; x++)
        expQ.push_back({8'(x), 8'(y), COL});
  endtask

  task automatic drain(input string tag, input bit stallPat, output int got);
    int cyc;
    bit sawDone, stalled;
    logic [39:0] held;
    logic [63:0] expv;
    cyc = 0; got = 0; sawDone = 0; stalled = 0; held = '0;
    while (cyc < 3000 && !sawDone) begin
      pix_ready = stallPat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (stalled) begin
        check({tag, " valid held"}, pix_valid, 1);
        check({tag, " data held"}, {pix_x, pix_y, pix_colour}, held);
        if (!pix_valid) stalled = 0;
      end
      if (frame_done) begin
        sawDone = 1;
        check({tag, " queue empty at done"}, expQ.size(), 0);
      end else if (pix_valid) begin
        if (pix_ready) begin
          if (expQ.size() > 0) expv = {24'h0, expQ.pop_front()};
          else                 expv = '1;
          check({tag, " pixel"}, {24'h0, pix_x, pix_y, pix_colour}, expv);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = {pix_x, pix_y, pix_colour};
        end
      end
      step(1);
      cyc++;
    end
    check({tag, " frame_done seen"}, sawDone, 1);
    check({tag, " frame_done one cycle"}, frame_done, 0);
    pix_ready = 1'b0;
    expQ.delete();
  endtask

  initial begin
    int got, w;
    bit doneSeen;
    int nStart[5];

    // reset values
    step(2);
    check("rst note_count", note_count, 0);
    check("rst mem_full", mem_full, 0);
    check("rst pix_valid", pix_valid, 0);
    check("rst frame_done", frame_done, 0);
    check("rst pix_x", pix_x, 0);
    check("rst pix_y", pix_y, 0);
    check("rst pix_colour", pix_colour, 0);
    resetn = 1'b1;
    step(1);

    // single note, key 3, 0x10..0x30
    setMode(1);
    pulseRestart();
    tick(16);
    key_state[3] = 1'b1;
    step(1);
    tick(32);
    key_state[3] = 1'b0;
    step(3);
    check("single note_count", note_count, 1);

    setMode(0);
    tick(16);
    pushNote(3, 16, 48);
    startFrame();
    check("latency c1", pix_valid, 0);
    step(1);
    check("latency c2", pix_valid, 0);
    step(1);
    check("latency c3", pix_valid, 1);
    drain("single", 1'b0, got);
    check("single pixel count", got, 18);

    // same frame under backpressure
    pushNote(3, 16, 48);
    startFrame();
    drain("stall", 1'b1, got);
    check("stall pixel count", got, 18);

    // frame_start ignored in record mode
    setMode(1);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 5; i++) begin
      doneSeen |= pix_valid | frame_done;
      step(1);
    end
    check("record ignores frame_start", doneSeen, 0);

    // three simultaneous releases
    pulseRestart();
    check("restart clears count", note_count, 0);
    key_state[0] = 1'b1; key_state[5] = 1'b1; key_state[23] = 1'b1;
    step(1);
    tick(16);
    key_state = '0;
    step(1);
    check("simul count c1", note_count, 0);
    step(1);
    check("simul count c2", note_count, 1);
    step(1);
    check("simul count c3", note_count, 2);
    step(1);
    check("simul count c4", note_count, 3);

    setMode(0);
    tick(16);
    pushNote(0, 0, 16);
    pushNote(5, 0, 16);
    pushNote(23, 0, 16);
    startFrame();
    drain("simul", 1'b0, got);
    check("simul pixel count", got, 18);

    // clipping: a past note and a note spanning rows -3..10
    setMode(1);
    pulseRestart();
    tick(176);
    key_state[1] = 1'b1;
    step(1);
    tick(48);
    key_state[1] = 1'b0;
    step(2);
    tick(1328);
    key_state[2] = 1'b1;
    step(1);
    tick(208);
    key_state[2] = 1'b0;
    step(3);
    check("clip note_count", note_count, 2);

    setMode(0);
    tick(256);
    pushNote(1, 176, 224);
    pushNote(2, 1552, 1760);
    startFrame();
    drain("clip", 1'b0, got);
    check("clip pixel count", got, 66);

    // overflow with DEPTH=4
    setMode(1);
    pulseRestart();
    for (int i = 0; i < 5; i++) begin
      nStart[i] = tbNow;
      key_state[i] = 1'b1;
      step(1);
      tick(16);
      key_state[i] = 1'b0;
      step(3);
      if (i == 3) begin
        check("full at 4 count", note_count, 4);
        check("full at 4 flag", mem_full, 0);
      end
    end
    check("overflow count", note_count, 4);
    check("overflow mem_full", mem_full, 1);

    // mode change mid-frame
    setMode(0);
    startFrame();
    w = 0;
    while (!pix_valid && w < 10) begin
      step(1);
      w++;
    end
    check("midframe valid", pix_valid, 1);
    mode_record = 1'b1;
    step(1);
    tbNow = 0;
    check("mode change drops valid", pix_valid, 0);
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      doneSeen |= frame_done | pix_valid;
      step(1);
    end
    check("mode change no frame_done", doneSeen, 0);
    pulseRestart();
    check("restart count", note_count, 0);
    check("restart mem_full", mem_full, 0);

    // reset during DRAW
    key_state[4] = 1'b1;
    step(1);
    tick(16);
    key_state[4] = 1'b0;
    step(3);
    check("pre-reset count", note_count, 1);
    setMode(0);
    startFrame();
    w = 0;
    while (!pix_valid && w < 10) begin
      step(1);
      w++;
    end
    check("pre-reset valid", pix_valid, 1);
    #2 resetn = 1'b0;
    #1 check("reset drops valid", pix_valid, 0);
    step(2);
    resetn = 1'b1;
    step(1);
    check("post-reset count", note_count, 0);
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      doneSeen |= frame_done | pix_valid;
      step(1);
    end
    check("post-reset no frame_done", doneSeen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
